// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache between the CPU
// load/store stage and data memory; one word per line, stalls until memory completes.
module data_cache_ctrl #(
    parameter int ADDRESS_WIDTH = 18,
    parameter int DATA_WIDTH    = 32,
    parameter int INDEX_BITS    = 6
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpuRead,
    input  logic                     cpuWrite,
    input  logic [2:0]               cpuCtrl,
    input  logic [ADDRESS_WIDTH-1:0] cpuAddr,
    input  logic [DATA_WIDTH-1:0]    cpuWData,
    output logic [DATA_WIDTH-1:0]    cpuRData,
    output logic                     stall,
    output logic [2:0]               memCtrl,
    output logic [ADDRESS_WIDTH-1:0] memAddress,
    output logic                     memReadAllowed,
    output logic                     memWriteAllowed,
    output logic [DATA_WIDTH-1:0]    memWriteData,
    input  logic [DATA_WIDTH-1:0]    memReadData,
    input  logic                     memReady
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = ADDRESS_WIDTH - INDEX_BITS - 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REFILL = 3'd1,
        WRITE  = 3'd2,
        BYPASS = 3'd3,
        ACK    = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [DATA_WIDTH-1:0]   line_r [LINES];
    logic [TAG_W-1:0]        tag_r  [LINES];
    logic [LINES-1:0]        valid_r;
    logic [DATA_WIDTH-1:0]   bypass_r;
    logic                    hit_r;

    logic [INDEX_BITS-1:0]   index_s;
    logic [TAG_W-1:0]        tag_s;
    logic                    hit_s;
    logic                    misaligned_s;
    logic [DATA_WIDTH-1:0]   load_s;
    logic [DATA_WIDTH-1:0]   rdata_s;
    logic                    stall_s;
    logic                    rd_en_s;
    logic                    wr_en_s;
    logic [2:0]              ctrl_s;
    logic [ADDRESS_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0]   wdata_s;

    function automatic logic [DATA_WIDTH-1:0] extract_load(
        input logic [DATA_WIDTH-1:0] word,
        input logic [1:0]            lane,
        input logic [2:0]            ctrl
    );
        logic [DATA_WIDTH-1:0] shifted;
        shifted = word >> {lane, 3'b000};
        case (ctrl)
            3'b000:  extract_load = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b011:  extract_load = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            default: extract_load = word;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_store(
        input logic [DATA_WIDTH-1:0] old,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [1:0]            lane,
        input logic [2:0]            ctrl
    );
        logic [DATA_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] lane_data;
        mask      = {{(DATA_WIDTH-8){1'b0}}, 8'hFF} << {lane, 3'b000};
        lane_data = {{(DATA_WIDTH-8){1'b0}}, wdata[7:0]} << {lane, 3'b000};
        if (ctrl == 3'b000) begin
            merge_store = (old & ~mask) | lane_data;
        end else begin
            merge_store = wdata;
        end
    endfunction

    assign index_s      = cpuAddr[INDEX_BITS+1:2];
    assign tag_s        = cpuAddr[ADDRESS_WIDTH-1:INDEX_BITS+2];
    assign hit_s        = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign misaligned_s = (cpuCtrl != 3'b000) && (cpuCtrl != 3'b011) && (cpuAddr[1:0] != 2'b00);
    assign load_s       = extract_load(line_r[index_s], cpuAddr[1:0], cpuCtrl);

    // Next state and memory-side drive, decoded from the current state.
    always_comb begin
        state_s = state_r;
        stall_s = 1'b0;
        rd_en_s = 1'b0;
        wr_en_s = 1'b0;
        ctrl_s  = 3'b010;
        addr_s  = {ADDRESS_WIDTH{1'b0}};
        wdata_s = {DATA_WIDTH{1'b0}};
        rdata_s = {DATA_WIDTH{1'b0}};
        case (state_r)
            IDLE: begin
                if (cpuWrite) begin
                    stall_s = 1'b1;
                    state_s = WRITE;
                end else if (cpuRead) begin
                    if (misaligned_s) begin
                        stall_s = 1'b1;
                        state_s = BYPASS;
                    end else if (hit_s) begin
                        rdata_s = load_s;
                    end else begin
                        stall_s = 1'b1;
                        state_s = REFILL;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REFILL: begin
                stall_s = 1'b1;
                rd_en_s = 1'b1;
                ctrl_s  = 3'b010;
                addr_s  = {cpuAddr[ADDRESS_WIDTH-1:2], 2'b00};
                state_s = memReady ? IDLE : REFILL;
            end
            WRITE: begin
                stall_s = 1'b1;
                wr_en_s = 1'b1;
                ctrl_s  = cpuCtrl;
                addr_s  = cpuAddr;
                wdata_s = cpuWData;
                state_s = memReady ? ACK : WRITE;
            end
            BYPASS: begin
                stall_s = 1'b1;
                rd_en_s = 1'b1;
                ctrl_s  = cpuCtrl;
                addr_s  = cpuAddr;
                state_s = memReady ? ACK : BYPASS;
            end
            ACK: begin
                if (cpuRead && !cpuWrite) begin
                    rdata_s = bypass_r;
                end else begin
                    rdata_s = {DATA_WIDTH{1'b0}};
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Reset forces the CPU- and memory-facing handshakes quiet immediately.
    assign stall           = rst_n & stall_s;
    assign memReadAllowed  = rst_n & rd_en_s;
    assign memWriteAllowed = rst_n & wr_en_s;
    assign cpuRData        = rst_n ? rdata_s : {DATA_WIDTH{1'b0}};
    assign memCtrl         = ctrl_s;
    assign memAddress      = addr_s;
    assign memWriteData    = wdata_s;

    // Control state: FSM, valid bits, store-hit flag and bypass word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            valid_r  <= {LINES{1'b0}};
            bypass_r <= {DATA_WIDTH{1'b0}};
            hit_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == IDLE && cpuWrite) begin
                hit_r <= hit_s;
            end
            if (state_r == BYPASS && memReady) begin
                bypass_r <= memReadData;
            end
            if (state_r == REFILL && memReady) begin
                valid_r[index_s] <= 1'b1;
            end
        end
    end

    // Line data and tags; only meaningful where the valid bit is set.
    always_ff @(posedge clk) begin
        if (rst_n && state_r == REFILL && memReady) begin
            line_r[index_s] <= memReadData;
            tag_r[index_s]  <= tag_s;
        end else if (rst_n && state_r == WRITE && memReady && hit_r) begin
            line_r[index_s] <= merge_store(line_r[index_s], cpuWData, cpuAddr[1:0], cpuCtrl);
        end
    end
endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: directed scenarios plus random traffic
// against a transaction-level model (memory contents + which word each index holds).
module tb_data_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpuRead = 1'b0;
    logic        cpuWrite = 1'b0;
    logic [2:0]  cpuCtrl = 3'b010;
    logic [17:0] cpuAddr = 18'h0;
    logic [31:0] cpuWData = 32'h0;
    logic [31:0] cpuRData;
    logic        stall;
    logic [2:0]  memCtrl;
    logic [17:0] memAddress;
    logic        memReadAllowed;
    logic        memWriteAllowed;
    logic [31:0] memWriteData;
    logic [31:0] memReadData = 32'h0;
    logic        memReady = 1'b0;

    always #5 clk = ~clk;

    data_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpuRead(cpuRead), .cpuWrite(cpuWrite), .cpuCtrl(cpuCtrl),
        .cpuAddr(cpuAddr), .cpuWData(cpuWData), .cpuRData(cpuRData), .stall(stall),
        .memCtrl(memCtrl), .memAddress(memAddress),
        .memReadAllowed(memReadAllowed), .memWriteAllowed(memWriteAllowed),
        .memWriteData(memWriteData), .memReadData(memReadData), .memReady(memReady)
    );

    int vectors = 0;
    int errs = 0;
    logic [31:0] mem [int];
    int resident [int];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] mem_rd(input int wa);
        if (mem.exists(wa)) return mem[wa];
        else return (32'(wa) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input int lane, input logic [2:0] ctrl);
        logic [7:0] b;
        b = w[8*lane +: 8];
        if (ctrl == 3'b000) return {{24{b[7]}}, b};
        else if (ctrl == 3'b011) return {24'h0, b};
        else return w;
    endfunction

    // One CPU request from issue to completion; memory answers after `delay` strobe cycles.
    task automatic req(input logic wr, input logic rd, input logic [2:0] ctrl, input logic [17:0] addr,
                       input logic [31:0] wd, input int delay,
                       output logic [31:0] rdata, output int stalls);
        int wa;
        int idx;
        int lane;
        int kind;
        int waited;
        bit done;
        bit is_word;
        logic [17:0] want_addr;
        logic [2:0]  want_ctrl;
        logic [31:0] nw;
        wa      = int'(addr[17:2]);
        idx     = int'(addr[7:2]);
        lane    = int'(addr[1:0]);
        is_word = !(ctrl == 3'b000 || ctrl == 3'b011);
        if (wr) kind = 2;
        else if (is_word && lane != 0) kind = 3;
        else if (resident.exists(idx) && resident[idx] == wa) kind = 0;
        else kind = 1;
        want_addr = (kind == 1) ? {addr[17:2], 2'b00} : addr;
        want_ctrl = (kind == 1) ? 3'b010 : ctrl;
        cpuWrite = wr; cpuRead = rd; cpuCtrl = ctrl; cpuAddr = addr; cpuWData = wd;
        stalls = 0; waited = 0; done = 1'b0; rdata = 32'h0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (!stall) begin
                done = 1'b1;
                rdata = cpuRData;
                check("done_strobes", {30'h0, memReadAllowed, memWriteAllowed}, 32'h0);
            end else begin
                stalls++;
                if (memReadAllowed || memWriteAllowed) begin
                    check("strobe_rd", 32'(memReadAllowed), 32'(kind != 2));
                    check("strobe_wr", 32'(memWriteAllowed), 32'(kind == 2));
                    check("mem_addr", 32'(memAddress), 32'(want_addr));
                    check("mem_ctrl", 32'(memCtrl), 32'(want_ctrl));
                    if (kind == 2) check("mem_wdata", memWriteData, wd);
                    if (waited >= delay) begin
                        memReady = 1'b1;
                        if (kind == 2) begin
                            if (ctrl == 3'b000) begin
                                nw = mem_rd(wa);
                                nw[8*lane +: 8] = wd[7:0];
                                mem[wa] = nw;
                            end else begin
                                mem[wa] = wd;
                            end
                        end
                        memReadData = mem_rd(wa);
                    end else begin
                        waited++;
                    end
                end
                @(negedge clk);
                memReady = 1'b0;
                memReadData = $urandom;
            end
        end
        if (!done) check("timeout", 32'h0, 32'h1);
        if (kind == 1) resident[idx] = wa;
        check("stall_cycles", 32'(stalls), (kind == 0) ? 32'h0 : 32'(2 + delay));
        if (rd && !wr) begin
            if (kind == 3) check("bypass_data", rdata, mem_rd(wa));
            else check("load_data", rdata, load_val(mem_rd(wa), lane, ctrl));
        end
        @(negedge clk);
        cpuRead = 1'b0; cpuWrite = 1'b0;
    endtask

    logic [31:0] rd_v;
    int st;
    logic [9:0] tag_pool [4] = '{10'h100, 10'h101, 10'h200, 10'h3FF};
    logic [2:0] rctl_pool [4] = '{3'b000, 3'b011, 3'b010, 3'b111};

    initial begin
        mem[int'(18'h10000 >> 2)] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        #1;
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_strobes", {30'h0, memReadAllowed, memWriteAllowed}, 32'h0);
        check("reset_rdata", cpuRData, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: cold miss then hit
        req(1'b0, 1'b1, 3'b010, 18'h10000, 32'h0, 0, rd_v, st);
        check("t1_data", rd_v, 32'hDEADBEEF);
        check("t1_stalls", 32'(st), 32'h2);
        req(1'b0, 1'b1, 3'b010, 18'h10000, 32'h0, 0, rd_v, st);
        check("t1_hit_stalls", 32'(st), 32'h0);
        // T2: signed / unsigned byte loads
        req(1'b1, 1'b0, 3'b010, 18'h10000, 32'h80FF1234, 0, rd_v, st);
        req(1'b0, 1'b1, 3'b000, 18'h10003, 32'h0, 0, rd_v, st);
        check("t2_lb", rd_v, 32'hFFFFFF80);
        req(1'b0, 1'b1, 3'b011, 18'h10003, 32'h0, 0, rd_v, st);
        check("t2_lbu", rd_v, 32'h00000080);
        // T3: byte store into a hit line
        req(1'b1, 1'b0, 3'b010, 18'h10000, 32'hDEADBEEF, 0, rd_v, st);
        req(1'b1, 1'b0, 3'b000, 18'h10001, 32'h000000AB, 0, rd_v, st);
        req(1'b0, 1'b1, 3'b010, 18'h10000, 32'h0, 0, rd_v, st);
        check("t3_data", rd_v, 32'hDEADABEF);
        check("t3_stalls", 32'(st), 32'h0);
        // T4: conflict eviction
        req(1'b0, 1'b1, 3'b010, 18'h10100, 32'h0, 0, rd_v, st);
        req(1'b0, 1'b1, 3'b010, 18'h10000, 32'h0, 0, rd_v, st);
        check("t4_evicted", 32'(st), 32'h2);
        // T5: slow memory
        req(1'b0, 1'b1, 3'b010, 18'h10204, 32'h0, 5, rd_v, st);
        req(1'b1, 1'b0, 3'b010, 18'h10204, 32'h12345678, 5, rd_v, st);
        check("t5_wr_stalls", 32'(st), 32'h7);
        // T6: reset during refill
        cpuRead = 1'b1; cpuCtrl = 3'b010; cpuAddr = 18'h20004;
        @(negedge clk);
        #1;
        check("t6_refill_strobe", 32'(memReadAllowed), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("t6_rst_rd", 32'(memReadAllowed), 32'h0);
        check("t6_rst_wr", 32'(memWriteAllowed), 32'h0);
        check("t6_rst_stall", 32'(stall), 32'h0);
        check("t6_rst_rdata", cpuRData, 32'h0);
        cpuRead = 1'b0;
        rst_n = 1'b1;
        resident.delete();
        @(negedge clk);
        req(1'b0, 1'b1, 3'b010, 18'h10000, 32'h0, 0, rd_v, st);
        check("t6_miss_after_rst", 32'(st), 32'h2);
        // T7: misaligned word load bypasses the cache
        req(1'b0, 1'b1, 3'b010, 18'h10002, 32'h0, 0, rd_v, st);
        req(1'b0, 1'b1, 3'b010, 18'h10002, 32'h0, 1, rd_v, st);
        check("t7_bypass_again", 32'(st), 32'h3);

        // Random traffic over a small address pool to mix hits, misses and conflicts.
        for (int n = 0; n < 200; n++) begin
            logic wr;
            logic rd;
            logic [2:0] ctl;
            logic [17:0] a;
            a = {tag_pool[$urandom % 4], 6'($urandom % 8), 2'($urandom)};
            wr = (($urandom % 10) < 3);
            rd = wr ? 1'($urandom) : 1'b1;
            ctl = wr ? ((($urandom % 2) == 0) ? 3'b000 : 3'b010) : rctl_pool[$urandom % 4];
            if (($urandom % 8) == 0) begin
                #1;
                check("idle_stall", 32'(stall), 32'h0);
                check("idle_strobes", {30'h0, memReadAllowed, memWriteAllowed}, 32'h0);
                @(negedge clk);
            end
            req(wr, rd, ctl, a, $urandom, int'($urandom % 4), rd_v, st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
